mul_op_sequencer: RTL and testbench
===================================

Name: mul_op_sequencer

Overview:
- Upstream operand front-end for the shift/add multiply datapath (regA/regB/regP + controlfsm).
- Accepts an operand pair over a valid/ready handshake and drives both operands onto the shared 15-bit bus with ld_a/ld_b strobes.
- Clears P, pulses start, waits for eqz, then captures P and returns it over a second valid/ready handshake.
- Also handles the B==0 fast path and a completion timeout.

Parameters:
- WIDTH, 15, operand/bus/product width.
- TIMEOUT, 32800, maximum cycles spent in WAIT before an error result is returned; must be < 2^16.

Ports:
- clk  in  1  rising-edge clock.
- rst  in  1  synchronous active-low reset.
- in_valid  in  1  operand pair valid.
- in_ready  out  1  sequencer can accept an operand pair.
- in_a  in  WIDTH  multiplicand.
- in_b  in  WIDTH  multiplier (repeat count).
- bus_out  out  WIDTH  drives datapath bus_in.
- ld_a  out  1  load regA from bus.
- ld_b  out  1  load regB from bus.
- clr_p  out  1  clear regP.
- start  out  1  one-cycle start pulse to controlfsm.
- eqz  in  1  datapath flag, regB == 0.
- p_in  in  WIDTH  regP contents.
- res_valid  out  1  result available.
- res_ready  in  1  consumer accepts result.
- res_data  out  WIDTH  product (mod 2^WIDTH).
- res_err  out  1  result produced by timeout.

Behaviour:
- Reset (rst==0 at a clk edge): state=IDLE, wait counter=0, operand/result registers=0, all outputs 0. in_ready is 0 while rst==0.
- States: IDLE, LOAD_A, LOAD_B, CLEAR, START, WAIT, SETTLE, RESULT.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready, latch in_a→a_q and in_b→b_q.
  - If in_b==0: res_data←0, res_err←0, go to RESULT (datapath untouched).
  - Otherwise go to LOAD_A.
- LOAD_A: bus_out=a_q, ld_a=1 for exactly one cycle → LOAD_B.
- LOAD_B: bus_out=b_q, ld_b=1 for exactly one cycle → CLEAR.
- CLEAR: clr_p=1 for one cycle, bus_out=0 → START.
- START: start=1 for one cycle, wait counter←0 → WAIT.
- WAIT:
  - eqz is ignored in the first WAIT cycle.
  - From the second WAIT cycle, eqz==1 → SETTLE.
  - Otherwise the counter increments. When counter reaches TIMEOUT-1 with eqz still 0: res_data←p_in, res_err←1 → RESULT.
- SETTLE: one cycle so the final add lands in regP. res_data←p_in sampled at the end of this cycle, res_err←0 → RESULT.
- RESULT:
  - res_valid=1; res_data/res_err held stable until res_valid&&res_ready.
  - On the handshake, go to IDLE. The next operand can be accepted one cycle later (no same-cycle turnaround).
- Outside LOAD_A/LOAD_B, bus_out=0. ld_a, ld_b, clr_p and start are never high in the same cycle (one-hot strobes).
- in_ready=0 in every state except IDLE; in_valid is ignored outside IDLE.
- Latency, in_valid accept → res_valid, B≠0: 1(LOAD_A)+1(LOAD_B)+1(CLEAR)+1(START)+N(WAIT)+1(SETTLE) cycles. N = cycles until eqz seen, N ≥ 2.
- Latency for B==0: res_valid is high the cycle after accept.
- Arithmetic: no arithmetic in this block. The product wraps mod 2^WIDTH in the datapath and is passed through unmodified.
- Reset mid-operation (any state): next cycle is IDLE with all strobes/res_valid low. An in-flight result is discarded. The datapath is not cleared by this block; the next job reissues clr_p.
- res_ready asserted while res_valid==0: no effect.

Test Plan:
- Reset: hold rst=0 for 3 cycles with in_valid=1 → in_ready=0, res_valid=0, all strobes 0. Release → in_ready=1 next cycle.
- Basic multiply a=7, b=5 with behavioural datapath model → strobe order ld_a(bus=7), ld_b(bus=5), clr_p, start, each exactly one cycle. Then res_valid with res_data=35, res_err=0.
- Zero multiplier a=123, b=0 → no ld_a/ld_b/clr_p/start pulses; res_valid the next cycle, res_data=0.
- Wrap-around: a=0x4000, b=3 → res_data=0x4000 (0xC000 mod 2^15), res_err=0.
- Backpressure: res_ready=0 for 10 cycles after res_valid → res_data stable and in_ready=0 throughout. res_ready=1 → IDLE, in_ready=1 one cycle later.
- Timeout with TIMEOUT=16 and eqz tied 0 → res_valid exactly 16 WAIT cycles after start, res_err=1.
- Mid-op reset: assert rst=0 during WAIT → next cycle state IDLE, res_valid=0. A new a=3, b=4 job then returns 12.

Source files
------------

// File: rtl/mul_op_sequencer.sv
// Operand front-end for the shift/add multiplier: loads A/B over the shared bus,
// kicks the control FSM, waits for eqz (or a timeout) and returns P over valid/ready.
module mul_op_sequencer #(
  parameter int WIDTH   = 15,
  parameter int TIMEOUT = 32800
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  output logic [WIDTH-1:0] bus_out,
  output logic             ld_a,
  output logic             ld_b,
  output logic             clr_p,
  output logic             start,
  input  logic             eqz,
  input  logic [WIDTH-1:0] p_in,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [WIDTH-1:0] res_data,
  output logic             res_err
);

  typedef enum logic [2:0] {
    IDLE, LOAD_A, LOAD_B, CLEAR, START, WAIT, SETTLE, RESULT
  } state_t;

  localparam logic [15:0] CNT_LAST = 16'(TIMEOUT - 1);

  state_t           state, state_nx;
  logic [15:0]      cnt, cnt_nx;
  logic [WIDTH-1:0] a_q, a_nx, b_q, b_nx, data_nx;
  logic             err_nx;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state    <= IDLE;
      cnt      <= '0;
      a_q      <= '0;
      b_q      <= '0;
      res_data <= '0;
      res_err  <= 1'b0;
    end else begin
      state    <= state_nx;
      cnt      <= cnt_nx;
      a_q      <= a_nx;
      b_q      <= b_nx;
      res_data <= data_nx;
      res_err  <= err_nx;
    end
  end

  always_comb begin
    state_nx  = state;
    cnt_nx    = cnt;
    a_nx      = a_q;
    b_nx      = b_q;
    data_nx   = res_data;
    err_nx    = res_err;
    in_ready  = 1'b0;
    bus_out   = '0;
    ld_a      = 1'b0;
    ld_b      = 1'b0;
    clr_p     = 1'b0;
    start     = 1'b0;
    res_valid = 1'b0;
    case (state)
      IDLE: begin
        in_ready = rst;
        if (in_valid && rst) begin
          a_nx = in_a;
          b_nx = in_b;
          // B==0 needs no datapath work: answer directly
          if (in_b == '0) begin
            data_nx  = '0;
            err_nx   = 1'b0;
            state_nx = RESULT;
          end else begin
            state_nx = LOAD_A;
          end
        end
      end
      LOAD_A: begin
        bus_out  = a_q;
        ld_a     = 1'b1;
        state_nx = LOAD_B;
      end
      LOAD_B: begin
        bus_out  = b_q;
        ld_b     = 1'b1;
        state_nx = CLEAR;
      end
      CLEAR: begin
        clr_p    = 1'b1;
        state_nx = START;
      end
      START: begin
        start    = 1'b1;
        cnt_nx   = '0;
        state_nx = WAIT;
      end
      WAIT: begin
        // first WAIT cycle (cnt==0) still sees eqz from before the controller ran
        if (cnt != '0 && eqz) begin
          state_nx = SETTLE;
        end else if (cnt == CNT_LAST) begin
          data_nx  = p_in;
          err_nx   = 1'b1;
          state_nx = RESULT;
        end else begin
          cnt_nx = cnt + 16'd1;
        end
      end
      SETTLE: begin
        data_nx  = p_in;
        err_nx   = 1'b0;
        state_nx = RESULT;
      end
      RESULT: begin
        res_valid = 1'b1;
        if (res_ready) state_nx = IDLE;
      end
      default: state_nx = IDLE;
    endcase
  end

endmodule

// File: tb/tb_mul_op_sequencer.sv
// Directed bench for mul_op_sequencer with a behavioural shift/add datapath model.
module tb_mul_op_sequencer;
  localparam int W = 15;

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid, in_ready, ld_a, ld_b, clr_p, start, eqz, res_valid, res_ready, res_err;
  logic [W-1:0] in_a, in_b, bus_out, p_in, res_data;

  // second instance: short timeout, eqz stuck low, fixed P
  logic         t_valid, t_in_ready, t_ld_a, t_ld_b, t_clr_p, t_start, t_res_valid, t_res_err;
  logic         t_eqz;
  logic [W-1:0] t_bus, t_res_data, t_p;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  mul_op_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .in_a(in_a), .in_b(in_b), .bus_out(bus_out), .ld_a(ld_a), .ld_b(ld_b),
    .clr_p(clr_p), .start(start), .eqz(eqz), .p_in(p_in),
    .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_err(res_err)
  );

  mul_op_sequencer #(.WIDTH(W), .TIMEOUT(16)) dut_to (
    .clk(clk), .rst(rst), .in_valid(t_valid), .in_ready(t_in_ready),
    .in_a(in_a), .in_b(in_b), .bus_out(t_bus), .ld_a(t_ld_a), .ld_b(t_ld_b),
    .clr_p(t_clr_p), .start(t_start), .eqz(t_eqz), .p_in(t_p),
    .res_valid(t_res_valid), .res_ready(res_ready), .res_data(t_res_data), .res_err(t_res_err)
  );

  assign t_eqz = 1'b0;
  assign t_p   = 15'h1234;

  // behavioural datapath: regA, regB, regP and a repeat-add controller
  logic [W-1:0] ra = '0, rb = '0, rp = '0;
  logic         run = 1'b0;
  always @(posedge clk) begin
    if (ld_a) ra <= bus_out;
    if (ld_b) rb <= bus_out;
    else if (run && rb != 0) rb <= rb - 1'b1;
    if (clr_p) rp <= '0;
    else if (run && rb != 0) rp <= rp + ra;
    if (start) run <= 1'b1;
    else if (ld_a || ld_b || clr_p || rb == 0) run <= 1'b0;
  end
  assign eqz  = (rb == 0);
  assign p_in = rp;

  function automatic logic [4:0] strobes();
    return {ld_a, ld_b, clr_p, start, res_valid};
  endfunction

  task automatic test_reset();
    rst = 1'b0; in_valid = 1'b1; in_a = 15'd1; in_b = 15'd1; res_ready = 1'b0; t_valid = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      vectors++;
      if (in_ready !== 1'b0 || strobes() !== 5'b0) begin
        miscompares++;
        $display("FAIL reset_hold cyc%0d: in_ready=%b strobes=%b, want 0/00000", i, in_ready, strobes());
      end
    end
    in_valid = 1'b0; rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || strobes() !== 5'b0) begin
      miscompares++;
      $display("FAIL reset_release: in_ready=%b strobes=%b, want 1/00000", in_ready, strobes());
    end
  endtask

  // one full job with strobe-sequence and result checks
  task automatic test_job(input logic [W-1:0] a, input logic [W-1:0] b, input logic [W-1:0] exp);
    int cyc;
    in_a = a; in_b = b; in_valid = 1'b1; res_ready = 1'b0;
    vectors++;
    if (in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL job_accept a=%0d b=%0d: in_ready=%b, want 1", a, b, in_ready);
    end
    @(negedge clk);
    in_valid = 1'b0;
    if (b != 0) begin
      vectors++;
      if (strobes() !== 5'b10000 || bus_out !== a) begin
        miscompares++;
        $display("FAIL load_a: strobes=%b bus=%0h, want 10000/%0h", strobes(), bus_out, a);
      end
      @(negedge clk);
      vectors++;
      if (strobes() !== 5'b01000 || bus_out !== b) begin
        miscompares++;
        $display("FAIL load_b: strobes=%b bus=%0h, want 01000/%0h", strobes(), bus_out, b);
      end
      @(negedge clk);
      vectors++;
      if (strobes() !== 5'b00100 || bus_out !== '0) begin
        miscompares++;
        $display("FAIL clear: strobes=%b bus=%0h, want 00100/0", strobes(), bus_out);
      end
      @(negedge clk);
      vectors++;
      if (strobes() !== 5'b00010 || bus_out !== '0) begin
        miscompares++;
        $display("FAIL start: strobes=%b bus=%0h, want 00010/0", strobes(), bus_out);
      end
      cyc = 0;
      do begin
        @(negedge clk);
        cyc++;
        if (!res_valid && (strobes() !== 5'b0 || in_ready !== 1'b0)) begin
          vectors++; miscompares++;
          $display("FAIL wait_quiet: strobes=%b in_ready=%b, want 00000/0", strobes(), in_ready);
        end
      end while (!res_valid && cyc < 300);
      vectors++;
      if (!res_valid) begin
        miscompares++;
        $display("FAIL job_timeout_tb: res_valid=0 after %0d cycles, want 1", cyc);
      end
    end else begin
      vectors++;
      if (strobes() !== 5'b00001) begin
        miscompares++;
        $display("FAIL zero_fast: strobes=%b, want 00001", strobes());
      end
    end
    vectors++;
    if (res_data !== exp || res_err !== 1'b0) begin
      miscompares++;
      $display("FAIL result a=%0d b=%0d: data=%0h err=%b, want %0h/0", a, b, res_data, res_err, exp);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    vectors++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL handshake: res_valid=%b in_ready=%b, want 0/1", res_valid, in_ready);
    end
  endtask

  task automatic test_backpressure();
    int cyc;
    in_a = 15'd6; in_b = 15'd7; in_valid = 1'b1; res_ready = 1'b0;
    @(negedge clk);
    cyc = 0;
    while (!res_valid && cyc < 300) begin
      @(negedge clk);
      cyc++;
    end
    for (int i = 0; i < 10; i++) begin
      vectors++;
      if (res_valid !== 1'b1 || res_data !== 15'd42 || in_ready !== 1'b0) begin
        miscompares++;
        $display("FAIL backpressure cyc%0d: valid=%b data=%0d in_ready=%b, want 1/42/0",
                 i, res_valid, res_data, in_ready);
      end
      @(negedge clk);
    end
    in_valid = 1'b0; res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    vectors++;
    if (res_valid !== 1'b0 || in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_release: res_valid=%b in_ready=%b, want 0/1", res_valid, in_ready);
    end
  endtask

  task automatic test_timeout();
    int waits;
    in_a = 15'd1; in_b = 15'd1; t_valid = 1'b1;
    @(negedge clk);
    t_valid = 1'b0;
    waits = 0;
    while (!t_start && waits < 10) begin
      @(negedge clk);
      waits++;
    end
    waits = 0;
    @(negedge clk);
    while (!t_res_valid && waits < 100) begin
      waits++;
      @(negedge clk);
    end
    vectors++;
    if (waits !== 16 || t_res_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_cycles: wait=%0d valid=%b, want 16/1", waits, t_res_valid);
    end
    vectors++;
    if (t_res_err !== 1'b1 || t_res_data !== 15'h1234) begin
      miscompares++;
      $display("FAIL timeout_result: err=%b data=%0h, want 1/1234", t_res_err, t_res_data);
    end
    res_ready = 1'b1;
    @(negedge clk);
    res_ready = 1'b0;
    vectors++;
    if (t_res_valid !== 1'b0 || t_in_ready !== 1'b1) begin
      miscompares++;
      $display("FAIL timeout_release: valid=%b in_ready=%b, want 0/1", t_res_valid, t_in_ready);
    end
  endtask

  task automatic test_midop_reset();
    in_a = 15'd9; in_b = 15'd1000; in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (8) @(negedge clk);  // LOAD_A..START then a few WAIT cycles
    rst = 1'b0;
    @(negedge clk);
    vectors++;
    if (strobes() !== 5'b0 || in_ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_reset: strobes=%b in_ready=%b, want 00000/0", strobes(), in_ready);
    end
    rst = 1'b1;
    @(negedge clk);
    vectors++;
    if (in_ready !== 1'b1 || res_valid !== 1'b0) begin
      miscompares++;
      $display("FAIL midop_idle: in_ready=%b res_valid=%b, want 1/0", in_ready, res_valid);
    end
    test_job(15'd3, 15'd4, 15'd12);
  endtask

  initial begin
    test_reset();
    test_job(15'd7, 15'd5, 15'd35);
    test_job(15'd123, 15'd0, 15'd0);
    test_job(15'h4000, 15'd3, 15'h4000);
    test_job(15'h7FFF, 15'd2, 15'h7FFE);
    test_backpressure();
    test_timeout();
    test_midop_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
